// File: rtl/sc_point_fsm_gen2.sv
// Falling-point controller for a COLS x ROWS LED matrix: owns the point position,
// serves left/right/drop/land/pause, and emits Moore strobes to the matrix datapath.
module sc_point_fsm_gen2 #(
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter bit WRAP      = 1'b0,
    parameter int START_COL = 3,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          SC_POINTFSM_CLOCK_50,
    input  logic          SC_POINTFSM_RESET_InHigh,
    input  logic          SC_POINTFSM_startButton_InLow,
    input  logic          SC_POINTFSM_leftButton_InLow,
    input  logic          SC_POINTFSM_rightButton_InLow,
    input  logic          SC_POINTFSM_T0_InLow,
    input  logic          SC_POINTFSM_blocked_InLow,
    output logic          SC_POINTFSM_clear_OutLow,
    output logic          SC_POINTFSM_load_OutLow,
    output logic [1:0]    SC_POINTFSM_shiftselection_Out,
    output logic          SC_POINTFSM_upcount_OutLow,
    output logic          SC_POINTFSM_clearCounter_OutLow,
    output logic [CW-1:0] SC_POINTFSM_col_Out,
    output logic [RW-1:0] SC_POINTFSM_row_Out,
    output logic          SC_POINTFSM_paused_Out
);
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_IDLE      = 4'd1,
        S_INIT      = 4'd2,
        S_RELEASE   = 4'd3,
        S_CHECK     = 4'd4,
        S_LEFT      = 4'd5,
        S_RIGHT     = 4'd6,
        S_DOWN      = 4'd7,
        S_LOAD      = 4'd8,
        S_CLEAR     = 4'd9,
        S_PAUSE_REL = 4'd10,
        S_PAUSE     = 4'd11
    } state_t;

    localparam logic [CW-1:0] L_START = CW'(START_COL);
    localparam logic [CW-1:0] L_CMAX  = CW'(COLS - 1);
    localparam logic [RW-1:0] L_RMAX  = RW'(ROWS - 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_left_edge, w_right_edge, w_any_btn;

    assign w_left_edge  = (r_col == '0);
    assign w_right_edge = (r_col == L_CMAX);
    assign w_any_btn    = !SC_POINTFSM_startButton_InLow || !SC_POINTFSM_leftButton_InLow ||
                          !SC_POINTFSM_rightButton_InLow;

    always_ff @(posedge SC_POINTFSM_CLOCK_50) begin
        if (SC_POINTFSM_RESET_InHigh) r_state <= S_RESET;
        else                          r_state <= w_next;
    end

    // Position registers change on the edge leaving the state that owns the update.
    always_ff @(posedge SC_POINTFSM_CLOCK_50) begin
        if (SC_POINTFSM_RESET_InHigh) begin
            r_col <= L_START;
            r_row <= '0;
        end else begin
            case (r_state)
                S_INIT, S_CLEAR: begin
                    r_col <= L_START;
                    r_row <= '0;
                end
                S_LEFT:  if (WRAP || !w_left_edge)  r_col <= w_left_edge ? L_CMAX : r_col - CW'(1);
                S_RIGHT: if (WRAP || !w_right_edge) r_col <= w_right_edge ? '0 : r_col + CW'(1);
                S_DOWN:  if (r_row != L_RMAX) r_row <= r_row + RW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:     w_next = S_IDLE;
            S_IDLE:      if (!SC_POINTFSM_startButton_InLow) w_next = S_INIT;
            S_INIT:      w_next = S_RELEASE;
            S_RELEASE:   if (!w_any_btn) w_next = S_CHECK;
            S_CHECK: begin
                if (!SC_POINTFSM_T0_InLow && (r_row == L_RMAX || !SC_POINTFSM_blocked_InLow))
                    w_next = S_LOAD;
                else if (!SC_POINTFSM_T0_InLow)          w_next = S_DOWN;
                else if (!SC_POINTFSM_leftButton_InLow)  w_next = S_LEFT;
                else if (!SC_POINTFSM_rightButton_InLow) w_next = S_RIGHT;
                else if (!SC_POINTFSM_startButton_InLow) w_next = S_PAUSE_REL;
            end
            S_LEFT, S_RIGHT: w_next = S_RELEASE;
            // Back to CHECK without a release wait so a held move is served next.
            S_DOWN:      w_next = S_CHECK;
            S_LOAD:      w_next = S_CLEAR;
            S_CLEAR:     w_next = S_RELEASE;
            S_PAUSE_REL: if (SC_POINTFSM_startButton_InLow) w_next = S_PAUSE;
            S_PAUSE:     if (!SC_POINTFSM_startButton_InLow) w_next = S_RELEASE;
            default:     w_next = S_RESET;
        endcase
    end

    always_comb begin
        SC_POINTFSM_clear_OutLow        = 1'b1;
        SC_POINTFSM_load_OutLow         = 1'b1;
        SC_POINTFSM_shiftselection_Out  = 2'b11;
        SC_POINTFSM_upcount_OutLow      = 1'b1;
        SC_POINTFSM_clearCounter_OutLow = 1'b1;
        SC_POINTFSM_paused_Out          = 1'b0;
        case (r_state)
            S_INIT: begin
                SC_POINTFSM_clear_OutLow        = 1'b0;
                SC_POINTFSM_clearCounter_OutLow = 1'b0;
            end
            S_LEFT:      if (WRAP || !w_left_edge)  SC_POINTFSM_shiftselection_Out = 2'b01;
            S_RIGHT:     if (WRAP || !w_right_edge) SC_POINTFSM_shiftselection_Out = 2'b10;
            S_DOWN:      SC_POINTFSM_upcount_OutLow      = 1'b0;
            S_LOAD:      SC_POINTFSM_load_OutLow         = 1'b0;
            S_CLEAR:     SC_POINTFSM_clearCounter_OutLow = 1'b0;
            S_PAUSE_REL, S_PAUSE: SC_POINTFSM_paused_Out = 1'b1;
            default: ;
        endcase
    end

    assign SC_POINTFSM_col_Out = r_col;
    assign SC_POINTFSM_row_Out = r_row;
endmodule

// File: tb/tb_sc_point_fsm_gen2.sv
// Scoreboard bench: a saturating instance is event-checked, a wrapping twin shares stimulus.
module tb_sc_point_fsm_gen2;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b1, left = 1'b1, right = 1'b1, t0 = 1'b1, blk = 1'b1;
    logic clr0, ld0, up0, cc0, p0, clr1, ld1, up1, cc1, p1;
    logic [1:0] sh0, sh1;
    logic [2:0] col0, row0, col1, row1;

    always #5 clk = ~clk;

    sc_point_fsm_gen2 #(.COLS(8), .ROWS(8), .WRAP(1'b0), .START_COL(3)) u0 (
        .SC_POINTFSM_CLOCK_50(clk), .SC_POINTFSM_RESET_InHigh(rst),
        .SC_POINTFSM_startButton_InLow(start), .SC_POINTFSM_leftButton_InLow(left),
        .SC_POINTFSM_rightButton_InLow(right), .SC_POINTFSM_T0_InLow(t0),
        .SC_POINTFSM_blocked_InLow(blk), .SC_POINTFSM_clear_OutLow(clr0),
        .SC_POINTFSM_load_OutLow(ld0), .SC_POINTFSM_shiftselection_Out(sh0),
        .SC_POINTFSM_upcount_OutLow(up0), .SC_POINTFSM_clearCounter_OutLow(cc0),
        .SC_POINTFSM_col_Out(col0), .SC_POINTFSM_row_Out(row0), .SC_POINTFSM_paused_Out(p0));

    sc_point_fsm_gen2 #(.COLS(8), .ROWS(8), .WRAP(1'b1), .START_COL(3)) u1 (
        .SC_POINTFSM_CLOCK_50(clk), .SC_POINTFSM_RESET_InHigh(rst),
        .SC_POINTFSM_startButton_InLow(start), .SC_POINTFSM_leftButton_InLow(left),
        .SC_POINTFSM_rightButton_InLow(right), .SC_POINTFSM_T0_InLow(t0),
        .SC_POINTFSM_blocked_InLow(blk), .SC_POINTFSM_clear_OutLow(clr1),
        .SC_POINTFSM_load_OutLow(ld1), .SC_POINTFSM_shiftselection_Out(sh1),
        .SC_POINTFSM_upcount_OutLow(up1), .SC_POINTFSM_clearCounter_OutLow(cc1),
        .SC_POINTFSM_col_Out(col1), .SC_POINTFSM_row_Out(row1), .SC_POINTFSM_paused_Out(p1));

    // Event bits: {clear, load, upcount, clearCounter, shift left, shift right}
    localparam logic [5:0] EV_INIT = 6'b100100, EV_LOAD = 6'b010000, EV_CLRC = 6'b000100;
    localparam logic [5:0] EV_UP = 6'b001000, EV_L = 6'b000010, EV_R = 6'b000001;

    typedef struct { logic [5:0] ev; int col; int row; } ev_t;
    typedef struct { string name; int c0; int c1; int row; int p; int sh0; int nl1; } lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];
    int  errors = 0, checks = 0, nl1 = 0;
    bit  done = 1'b0;

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic push_e(input logic [5:0] ev, input int c, input int r);
        ev_t e; e.ev = ev; e.col = c; e.row = r; ev_q.push_back(e);
    endtask
    task automatic push_l(input string nm, input int c0, input int c1, input int r,
                          input int p, input int s, input int n);
        lv_t l; l.name = nm; l.c0 = c0; l.c1 = c1; l.row = r; l.p = p; l.sh0 = s; l.nl1 = n;
        lv_q.push_back(l);
    endtask
    task automatic press_left();  left = 1'b0;  step(2); left = 1'b1;  step(3); endtask
    task automatic press_right(); right = 1'b0; step(2); right = 1'b1; step(3); endtask
    task automatic tick();        t0 = 1'b0;    step(1); t0 = 1'b1;    step(3); endtask

    // Monitor: pops an expected event whenever u0 strobes, and any queued level snapshot.
    initial begin
        logic [5:0] act;
        ev_t e;
        lv_t l;
        forever begin
            @(negedge clk);
            if (sh1 == 2'b01) nl1++;
            act = {~clr0, ~ld0, ~up0, ~cc0, sh0 == 2'b01, sh0 == 2'b10};
            if (act != 6'b0) begin
                checks++;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event act=%b col=%0d row=%0d", act, col0, row0);
                end else begin
                    e = ev_q.pop_front();
                    if (act != e.ev || int'(col0) != e.col || int'(row0) != e.row) begin
                        errors++;
                        $display("FAIL event act=%b col=%0d row=%0d exp=%b col=%0d row=%0d",
                                 act, col0, row0, e.ev, e.col, e.row);
                    end
                end
            end
            while (lv_q.size() > 0) begin
                l = lv_q.pop_front();
                checks++;
                if (int'(col0) != l.c0 || int'(col1) != l.c1 || int'(row0) != l.row ||
                    int'(p0) != l.p || int'(sh0) != l.sh0 || nl1 != l.nl1) begin
                    errors++;
                    $display("FAIL %s got c0=%0d c1=%0d row=%0d p=%0d sh0=%0d nl1=%0d exp %0d %0d %0d %0d %0d %0d",
                             l.name, col0, col1, row0, p0, sh0, nl1,
                             l.c0, l.c1, l.row, l.p, l.sh0, l.nl1);
                end
            end
            if (done) begin
                checks++;
                if (ev_q.size() != 0) begin
                    errors++;
                    $display("FAIL missing_events got %0d pending exp 0", ev_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        step(3);
        push_l("reset", 3, 3, 0, 0, 3, 0);
        step(1); rst = 1'b0; step(2);

        push_e(EV_INIT, 3, 0);
        start = 1'b0; step(3); start = 1'b1; step(3);
        push_l("init", 3, 3, 0, 0, 3, 0);

        for (int c = 3; c >= 1; c--) begin push_e(EV_L, c, 0); press_left(); end
        push_l("left_to_0", 0, 0, 0, 0, 3, 3);
        press_left();
        push_l("left_edge", 0, 7, 0, 0, 3, 4);
        push_e(EV_R, 0, 0); press_right();
        push_l("right", 1, 0, 0, 0, 3, 4);

        for (int r = 0; r < 7; r++) begin push_e(EV_UP, 1, r); tick(); end
        push_l("row7", 1, 0, 7, 0, 3, 4);
        push_e(EV_LOAD, 1, 7); push_e(EV_CLRC, 1, 7);
        tick(); step(2);
        push_l("landed_bottom", 3, 3, 0, 0, 3, 4);

        push_e(EV_UP, 3, 0); tick();
        push_e(EV_UP, 3, 1); tick();
        blk = 1'b0;
        push_e(EV_LOAD, 3, 2); push_e(EV_CLRC, 3, 2);
        tick(); blk = 1'b1; step(2);
        push_l("landed_blocked", 3, 3, 0, 0, 3, 4);

        push_e(EV_UP, 3, 0); push_e(EV_L, 3, 1);
        t0 = 1'b0; left = 1'b0; step(1); t0 = 1'b1; step(3); left = 1'b1; step(3);
        push_l("tick_beats_left", 2, 2, 1, 0, 3, 5);

        start = 1'b0; step(2); start = 1'b1; step(2);
        push_l("paused", 2, 2, 1, 1, 3, 5);
        tick(); tick(); press_left(); press_right();
        push_l("pause_hold", 2, 2, 1, 1, 3, 5);
        start = 1'b0; step(2);
        push_l("resume", 2, 2, 1, 0, 3, 5);
        start = 1'b1; step(3);

        push_e(EV_L, 2, 1);
        left = 1'b0; step(1); rst = 1'b1; step(1);
        push_l("reset_in_left", 3, 3, 0, 0, 3, 6);
        rst = 1'b0; left = 1'b1; step(4);
        done = 1'b1;
        step(5);
        $display("FAIL monitor_timeout got no summary exp summary");
        $fatal(1, "monitor did not finish");
    end
endmodule
